writeback_register_file: RTL and testbench
==========================================

// Module: writeback_register_file
// PURPOSE
//  - Architectural integer register file (x0..x31); the consumer of the writeback stage's write (RdW/ResultW/RegWriteW).
//  - Serves decode-stage reads with same-cycle write bypass, so writeback needs no half-cycle clocking.
//  - Adds a valid/ready debug read port and a committed-write counter for bring-up and verification.
// PARAMETERS
//  - XLEN     32  data width of each register
//  - NREGS    32  register count; address width = $clog2(NREGS)
//  - CNT_W    32  width of o_WriteCount
// PORTS
//  - i_Clk          in   1      clock; all state updates on rising edge
//  - i_Reset        in   1      synchronous, active-low reset
//  - i_RegWriteW    in   1      writeback write enable
//  - i_RdW          in   5      writeback destination register
//  - i_ResultW      in   XLEN   writeback data
//  - i_Rs1D         in   5      decode read address 1
//  - i_Rs2D         in   5      decode read address 2
//  - o_RD1D         out  XLEN   read data 1 (combinational)
//  - o_RD2D         out  XLEN   read data 2 (combinational)
//  - i_DbgReqValid  in   1      debug read request valid
//  - i_DbgAddr      in   5      debug read address
//  - o_DbgReqReady  out  1      debug request accepted when high with valid
//  - o_DbgRspValid  out  1      debug response valid
//  - o_DbgRspData   out  XLEN   debug response data
//  - i_DbgRspReady  in   1      debug response consumed when high with valid
//  - o_WriteCount   out  CNT_W  count of committed writes
//  - o_ParityErr    out  1      sticky parity error (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (i_Reset==0 at edge): all registers 0, o_WriteCount 0, debug FSM IDLE, o_DbgRspValid 0, o_DbgRspData 0, o_ParityErr 0.
//  - Reset mid-debug-transaction: pending response dropped; FSM goes to IDLE.
//  - Write commits at edge when i_RegWriteW && i_RdW!=0; i_RdW==0 writes are discarded and not counted.
//  - x0 reads always return 0, including during a write to x0.
//  - Read bypass: if i_RegWriteW && i_RdW!=0 && i_RdW==i_RsND, o_RDND = i_ResultW; otherwise the stored value.
//  - o_WriteCount increments by 1 per committed write; wraps from 2^CNT_W-1 to 0.
//  - Debug FSM: IDLE -> RESP on accept (valid && ready); RESP -> IDLE when i_DbgRspReady.
//  - o_DbgReqReady = (state==IDLE); at most one request outstanding; no back-to-back acceptance.
//  - Debug data is captured at the accept edge using the same bypass rule (a same-cycle write to that address is returned).
//  - Debug data is held stable while in RESP, even if the register is rewritten.
//  - Response latency is one cycle: o_DbgRspValid is high the cycle after accept.
// CONFIGURATION
//  - Macro REGFILE_PARITY_EN defined:
//    - each register stores an even-parity bit, computed from the write data;
//    - extra input i_ParityInjectW (1b) inverts the stored bit on that write;
//    - on every non-bypassed read of a nonzero address (RD1, RD2, debug capture), parity is recomputed;
//    - any mismatch sets o_ParityErr at the next edge; it clears only on reset.
//  - Macro undefined: no parity storage, no i_ParityInjectW port, o_ParityErr tied 0.
// STRUCTURE
//  - Package regfile_pkg: XLEN, REG_ADDR_W, typedef reg_addr_t, typedef xlen_t,
//    enum dbg_state_e {DBG_IDLE, DBG_RESP}.
//  - Sub-module regfile_dbg_port: debug valid/ready FSM and response register; takes the bypassed read value as input.
//  - Storage array, bypass muxes, write counter and parity logic stay in the top module.
// TESTING
//  - Reset then read x1..x31 on both ports -> all 0; o_WriteCount==0; o_DbgRspValid==0.
//  - Write x5=0xDEADBEEF with Rs1D=5 in the same cycle -> o_RD1D==0xDEADBEEF that cycle; next cycle still 0xDEADBEEF.
//  - Write x0=0x12345678 -> o_RD1D(Rs1D=0)==0; o_WriteCount unchanged.
//  - Debug read x5 with RspReady low for 3 cycles while writing x5=0x1 -> rsp 0xDEADBEEF held; ReqReady 0 until consumed.
//  - Preload o_WriteCount to 2^32-1 via 2^32-1 writes (or a force), then one write -> count 0.
//  - REGFILE_PARITY_EN: write x7=0xA5 with i_ParityInjectW=1, read Rs2D=7 -> o_ParityErr 1 next cycle, stays 1 until reset.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, types and debug FSM states for the writeback register file.
package regfile_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0] xlen_t;
  typedef enum logic {DBG_IDLE, DBG_RESP} dbg_state_e;
endpackage

// File: rtl/regfile_dbg_port.sv
// regfile_dbg_port: single-outstanding valid/ready debug read FSM holding the captured response.
module regfile_dbg_port
  import regfile_pkg::*;
#(
  parameter int DW = XLEN
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  input  logic [DW-1:0] rd_data,
  input  logic          rsp_ready,
  output logic          req_ready,
  output logic          accept,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data
);
  dbg_state_e state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  assign req_ready = state_q == DBG_IDLE;
  assign accept = req_valid && req_ready;
  assign rsp_valid = state_q == DBG_RESP;
  assign rsp_data = data_q;
  always_comb begin
    state_d = state_q == DBG_IDLE ? (accept ? DBG_RESP : DBG_IDLE) : (rsp_ready ? DBG_IDLE : DBG_RESP);
    data_d = accept ? rd_data : data_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= DBG_IDLE;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
    end
  end
endmodule

// File: rtl/writeback_register_file.sv
// writeback_register_file: x0..x31 register file with same-cycle write bypass, debug read port and write counter.
// Optional per-register even parity with sticky error when REGFILE_PARITY_EN is defined.
module writeback_register_file
  import regfile_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 32
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset,
  input  logic                     i_RegWriteW,
  input  logic [$clog2(NREGS)-1:0] i_RdW,
  input  logic [XLEN-1:0]          i_ResultW,
  input  logic [$clog2(NREGS)-1:0] i_Rs1D,
  input  logic [$clog2(NREGS)-1:0] i_Rs2D,
  output logic [XLEN-1:0]          o_RD1D,
  output logic [XLEN-1:0]          o_RD2D,
  input  logic                     i_DbgReqValid,
  input  logic [$clog2(NREGS)-1:0] i_DbgAddr,
  output logic                     o_DbgReqReady,
  output logic                     o_DbgRspValid,
  output logic [XLEN-1:0]          o_DbgRspData,
  input  logic                     i_DbgRspReady,
  output logic [CNT_W-1:0]         o_WriteCount,
  output logic                     o_ParityErr
`ifdef REGFILE_PARITY_EN
  ,
  input  logic                     i_ParityInjectW
`endif
);
  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic we, byp1, byp2, bypd, dbg_accept;
  logic [XLEN-1:0] dbg_rd;
  assign we = i_RegWriteW && i_RdW != '0;
  assign byp1 = we && i_RdW == i_Rs1D;
  assign byp2 = we && i_RdW == i_Rs2D;
  assign bypd = we && i_RdW == i_DbgAddr;
  assign o_RD1D = i_Rs1D == '0 ? '0 : byp1 ? i_ResultW : mem_q[i_Rs1D];
  assign o_RD2D = i_Rs2D == '0 ? '0 : byp2 ? i_ResultW : mem_q[i_Rs2D];
  assign dbg_rd = i_DbgAddr == '0 ? '0 : bypd ? i_ResultW : mem_q[i_DbgAddr];
  assign o_WriteCount = cnt_q;
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[i_RdW] = i_ResultW;
    cnt_d = cnt_q + CNT_W'(we);
  end
  always_ff @(posedge i_Clk) begin
    if (!i_Reset) begin
      mem_q <= '{default: '0};
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end
  regfile_dbg_port #(.DW(XLEN)) u_dbg (
    .clk      (i_Clk),
    .rst_n    (i_Reset),
    .req_valid(i_DbgReqValid),
    .rd_data  (dbg_rd),
    .rsp_ready(i_DbgRspReady),
    .req_ready(o_DbgReqReady),
    .accept   (dbg_accept),
    .rsp_valid(o_DbgRspValid),
    .rsp_data (o_DbgRspData)
  );
`ifdef REGFILE_PARITY_EN
  logic [NREGS-1:0] par_q, par_d;
  logic perr_q, perr_d;
  always_comb begin
    par_d = par_q;
    if (we) par_d[i_RdW] = ^i_ResultW ^ i_ParityInjectW;
    // only stored values are checked; bypassed data never touched the array
    perr_d = perr_q
      | (i_Rs1D != '0 && !byp1 && (^mem_q[i_Rs1D]) != par_q[i_Rs1D])
      | (i_Rs2D != '0 && !byp2 && (^mem_q[i_Rs2D]) != par_q[i_Rs2D])
      | (dbg_accept && i_DbgAddr != '0 && !bypd && (^mem_q[i_DbgAddr]) != par_q[i_DbgAddr]);
  end
  always_ff @(posedge i_Clk) begin
    if (!i_Reset) begin
      par_q <= '0;
      perr_q <= 1'b0;
    end else begin
      par_q <= par_d;
      perr_q <= perr_d;
    end
  end
  assign o_ParityErr = perr_q;
`else
  assign o_ParityErr = 1'b0;
`endif
endmodule

// File: tb/tb_writeback_register_file.sv
// tb_writeback_register_file: directed checks of bypass, x0, debug port, counter wrap and optional parity.
module tb_writeback_register_file;
  import regfile_pkg::*;
  localparam int CW = 8;
  logic clk = 0, rst_n = 0, we = 0, dv = 0, dr = 0, inj = 0;
  reg_addr_t rd = '0, rs1 = '0, rs2 = '0, da = '0;
  xlen_t res = '0, rd1, rd2, dbg_data;
  logic dbg_qr, dbg_v, perr;
  logic [CW-1:0] cnt;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  writeback_register_file #(.XLEN(32), .NREGS(32), .CNT_W(CW)) dut (
    .i_Clk(clk), .i_Reset(rst_n), .i_RegWriteW(we), .i_RdW(rd), .i_ResultW(res),
    .i_Rs1D(rs1), .i_Rs2D(rs2), .o_RD1D(rd1), .o_RD2D(rd2),
    .i_DbgReqValid(dv), .i_DbgAddr(da), .o_DbgReqReady(dbg_qr), .o_DbgRspValid(dbg_v),
    .o_DbgRspData(dbg_data), .i_DbgRspReady(dr), .o_WriteCount(cnt), .o_ParityErr(perr)
`ifdef REGFILE_PARITY_EN
    , .i_ParityInjectW(inj)
`endif
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    tick();
    tick();
    rst_n = 1;
    for (int i = 1; i < 32; i++) begin
      rs1 = reg_addr_t'(i);
      rs2 = reg_addr_t'(i);
      #1;
      chk($sformatf("reset_rd1_x%0d", i), rd1, 0);
      chk($sformatf("reset_rd2_x%0d", i), rd2, 0);
    end
    chk("reset_cnt", cnt, 0);
    chk("reset_rspv", dbg_v, 0);
    chk("reset_rspdata", dbg_data, 0);
    chk("reset_reqready", dbg_qr, 1);
    chk("reset_perr", perr, 0);
    // x5 write with same-cycle bypass
    we = 1; rd = 5; res = 32'hDEADBEEF; rs1 = 5; rs2 = 6;
    #1;
    chk("byp_rd1_x5", rd1, 32'hDEADBEEF);
    chk("byp_rd2_x6", rd2, 0);
    tick();
    we = 0;
    #1;
    chk("stored_rd1_x5", rd1, 32'hDEADBEEF);
    chk("cnt_after_x5", cnt, 1);
    // disabled write to x5 must not bypass or count
    rd = 5; res = 32'hFFFF; rs1 = 5;
    #1;
    chk("nowe_rd1_x5", rd1, 32'hDEADBEEF);
    tick();
    chk("nowe_cnt", cnt, 1);
    // x0 write discarded
    we = 1; rd = 0; res = 32'h12345678; rs1 = 0; rs2 = 0;
    #1;
    chk("x0_rd1_during", rd1, 0);
    chk("x0_rd2_during", rd2, 0);
    tick();
    we = 0;
    #1;
    chk("x0_rd1_after", rd1, 0);
    chk("x0_cnt", cnt, 1);
    // rs2 bypass on x9
    we = 1; rd = 9; res = 32'h55; rs2 = 9;
    #1;
    chk("byp_rd2_x9", rd2, 32'h55);
    tick();
    we = 0;
    chk("cnt_after_x9", cnt, 2);
    // debug read of x5 held while x5 is rewritten and response stalled
    dv = 1; da = 5; dr = 0;
    #1;
    chk("dbg_reqready_idle", dbg_qr, 1);
    tick();
    we = 1; rd = 5; res = 32'h1;
    #1;
    chk("dbg_rspv_lat1", dbg_v, 1);
    chk("dbg_data_x5", dbg_data, 32'hDEADBEEF);
    chk("dbg_reqready_busy", dbg_qr, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("dbg_hold_v_%0d", i), dbg_v, 1);
      chk($sformatf("dbg_hold_data_%0d", i), dbg_data, 32'hDEADBEEF);
      chk($sformatf("dbg_hold_rdy_%0d", i), dbg_qr, 0);
    end
    we = 0; dv = 0; dr = 1; rs1 = 5;
    #1;
    chk("x5_rewritten", rd1, 1);
    chk("cnt_after_stall", cnt, 5);
    tick();
    dr = 0;
    chk("dbg_consumed_v", dbg_v, 0);
    chk("dbg_consumed_rdy", dbg_qr, 1);
    // debug capture uses the same-cycle write
    dv = 1; da = 9; we = 1; rd = 9; res = 32'hCAFE0009;
    tick();
    dv = 0; we = 0;
    #1;
    chk("dbg_byp_data", dbg_data, 32'hCAFE0009);
    dr = 1;
    tick();
    dr = 0;
    // debug read of x0 returns 0
    dv = 1; da = 0;
    tick();
    dv = 0;
    #1;
    chk("dbg_x0_v", dbg_v, 1);
    chk("dbg_x0_data", dbg_data, 0);
    dr = 1;
    tick();
    dr = 0;
    // reset while a response is pending
    dv = 1; da = 5;
    tick();
    dv = 0;
    chk("pend_v", dbg_v, 1);
    rst_n = 0;
    tick();
    rst_n = 1; rs1 = 5;
    #1;
    chk("rst_mid_v", dbg_v, 0);
    chk("rst_mid_data", dbg_data, 0);
    chk("rst_mid_rdy", dbg_qr, 1);
    chk("rst_mid_cnt", cnt, 0);
    chk("rst_mid_x5", rd1, 0);
    // counter wrap at 2^CW-1
    for (int i = 0; i < 255; i++) begin
      we = 1; rd = reg_addr_t'((i % 31) + 1); res = xlen_t'(i);
      tick();
    end
    we = 0; rs1 = 7;
    #1;
    chk("cnt_max", cnt, 8'hFF);
    chk("x7_last", rd1, 32'hFE);
    we = 1; rd = 3; res = 32'h77;
    tick();
    we = 0;
    chk("cnt_wrap", cnt, 0);
    rs1 = 0; rs2 = 0;
`ifdef REGFILE_PARITY_EN
    we = 1; rd = 7; res = 32'hA5; inj = 1;
    tick();
    we = 0; inj = 0;
    chk("par_before_read", perr, 0);
    rs2 = 7;
    #1;
    chk("par_data_intact", rd2, 32'hA5);
    tick();
    chk("par_err_set", perr, 1);
    rs2 = 0;
    tick();
    tick();
    chk("par_err_sticky", perr, 1);
`else
    chk("perr_tied0", perr, 0);
`endif
    rst_n = 0;
    tick();
    rst_n = 1; rs1 = 7;
    #1;
    chk("final_perr", perr, 0);
    chk("final_cnt", cnt, 0);
    chk("final_x7", rd1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
